// File: rtl/core_pkg.sv
// core_pkg: shared types for the bus fabric -- target bus widths, fabric
// state encoding and the read-data steering helper.
package core_pkg;

   // Per-target data path width; encodings are fixed so TW can be given as raw bits.
   typedef enum logic [1:0] {
      BW8  = 2'd0,
      BW16 = 2'd1,
      BW32 = 2'd2
   } bus_width_t;

   // Fabric access sequencer states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DONE   = 2'd2,
      TERR   = 2'd3
   } fabric_state_t;

   // Read data returned to the CPU on an aborted or unmapped access.
   localparam logic [31:0] ERR_DATA = 32'hFFFF_FFFF;

   // Zero-extend the meaningful low lanes of a target's read word.
   function automatic logic [31:0] steer_rdata(input bus_width_t width,
                                               input logic [31:0] data);
      logic [31:0] result;
      case (width)
         BW8:     result = {24'h0, data[7:0]};
         BW16:    result = {16'h0, data[15:0]};
         default: result = data;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/bus_watchdog.sv
// bus_watchdog: counts CE cycles while enabled and flags when TIMEOUT cycles
// have been spent. Only instantiated when BUS_FABRIC_TIMEOUT_EN is defined.
module bus_watchdog #(
   parameter int TIMEOUT = 1023
) (
   input  logic CLK,
   input  logic RES,
   input  logic CE,
   input  logic CLR,
   input  logic EN,
   output logic EXPIRED
);
   localparam int            CW   = $clog2(TIMEOUT + 1);
   // EXPIRED is raised during the TIMEOUT-th enabled cycle, so the owner can
   // act on the same CE edge that completes the count.
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign EXPIRED = (cnt_q == LAST);

   // Next count: clear on request, otherwise advance until the limit is reached.
   always_comb begin
      cnt_d = cnt_q;
      if (CE) begin
         if (CLR) begin
            cnt_d = '0;
         end else if (EN && !EXPIRED) begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // Counter register.
   always_ff @(posedge CLK or posedge RES) begin
      if (RES) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/bus_fabric.sv
// bus_fabric: steers single CPU accesses to one of NT decoded targets,
// returns width-steered read data and signals completion or bus error.
// Define BUS_FABRIC_TIMEOUT_EN to abort accesses stalled in ACTIVE for
// TIMEOUT CE cycles; without it ACTIVE waits for the target indefinitely.
module bus_fabric
   import core_pkg::*;
#(
   parameter int                  NT      = 6,
   parameter bus_width_t [NT-1:0] TW      = {NT{BW16}},
   parameter int                  TIMEOUT = 1023
) (
   input  logic             CLK,
   input  logic             RES,
   input  logic             CE,
   input  logic [31:0]      A,
   input  logic [31:0]      D_O,
   output logic [31:0]      D_I,
   input  logic             RW,
   input  logic             BCYSTn,
   output logic             READYn,
   output logic             SZRQn,
   input  logic [NT-1:0]    T_SELn,
   output logic [NT-1:0]    T_CEn,
   output logic [NT-1:0]    T_WEn,
   input  logic [NT*32-1:0] T_DO,
   input  logic [NT-1:0]    T_READYn,
   output logic             BERR,
   output logic [31:0]      ERR_ADDR
);
   localparam int IW = (NT > 1) ? $clog2(NT) : 1;

   fabric_state_t state_q, state_d;
   logic [31:0]   addr_q, addr_d;
   logic          rw_q, rw_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [NT-1:0] t_cen_q, t_cen_d;
   logic          readyn_q, readyn_d;
   logic          szrqn_q, szrqn_d;
   logic          berr_q, berr_d;
   logic [31:0]   d_i_q, d_i_d;
   logic [31:0]   err_addr_q, err_addr_d;

   logic          sel_found;
   logic [IW-1:0] sel_idx;
   bus_width_t    sel_width;
   logic          cur_readyn;
   logic [31:0]   cur_rdata;
   bus_width_t    cur_width;
   logic          wd_expired;

   // Write data reaches the targets on a shared path outside this block.
   logic unused_wdata;
   assign unused_wdata = ^D_O;

   // Decode the lowest asserted select and mux the latched target's ready, data and width.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      sel_found  = 1'b0;
      sel_idx    = '0;
      sel_width  = BW8;
      cur_readyn = 1'b1;
      cur_rdata  = '0;
      cur_width  = BW8;
      // Scan downwards so the lowest-numbered asserted select is written last and wins.
      for (int i = NT - 1; i >= 0; i--) begin
         if (!T_SELn[i]) begin
            sel_found = 1'b1;
            sel_idx   = IW'(i);
            sel_width = TW[i];
         end
      end
      for (int i = 0; i < NT; i++) begin
         if (idx_q == IW'(i)) begin
            cur_readyn = T_READYn[i];
            cur_rdata  = T_DO[i*32 +: 32];
            cur_width  = TW[i];
         end
      end
   end

`ifdef BUS_FABRIC_TIMEOUT_EN
   logic wd_clr;
   logic wd_en;

   // The count restarts on the latch edge that moves IDLE to ACTIVE.
   assign wd_clr = (state_q == IDLE) && !BCYSTn && sel_found;
   assign wd_en  = (state_q == ACTIVE);

   bus_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .CLK     (CLK),
      .RES     (RES),
      .CE      (CE),
      .CLR     (wd_clr),
      .EN      (wd_en),
      .EXPIRED (wd_expired)
   );
`else
   assign wd_expired = 1'b0;
`endif

   // Sequencer next state and next values of all registered outputs; CE=0 holds everything.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rw_d       = rw_q;
      idx_d      = idx_q;
      t_cen_d    = t_cen_q;
      readyn_d   = readyn_q;
      szrqn_d    = szrqn_q;
      berr_d     = berr_q;
      d_i_d      = d_i_q;
      err_addr_d = err_addr_q;
      if (CE) begin
         case (state_q)
            IDLE: begin
               if (!BCYSTn) begin
                  addr_d = A;
                  rw_d   = RW;
                  if (sel_found) begin
                     idx_d   = sel_idx;
                     t_cen_d = ~(NT'(1) << sel_idx);
                     szrqn_d = (sel_width == BW32);
                     state_d = ACTIVE;
                  end else begin
                     readyn_d   = 1'b0;
                     berr_d     = 1'b1;
                     d_i_d      = ERR_DATA;
                     err_addr_d = A;
                     state_d    = TERR;
                  end
               end
            end
            ACTIVE: begin
               // Ready is tested first so it wins over a timeout in the same cycle.
               if (!cur_readyn) begin
                  d_i_d    = steer_rdata(cur_width, cur_rdata);
                  t_cen_d  = '1;
                  readyn_d = 1'b0;
                  state_d  = DONE;
               end else if (wd_expired) begin
                  t_cen_d    = '1;
                  szrqn_d    = 1'b1;
                  readyn_d   = 1'b0;
                  berr_d     = 1'b1;
                  d_i_d      = ERR_DATA;
                  err_addr_d = addr_q;
                  state_d    = TERR;
               end
            end
            DONE: begin
               readyn_d = 1'b1;
               szrqn_d  = 1'b1;
               state_d  = IDLE;
            end
            TERR: begin
               readyn_d = 1'b1;
               berr_d   = 1'b0;
               state_d  = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and output registers; reset abandons any access without a READYn or BERR pulse.
   always_ff @(posedge CLK or posedge RES) begin
      if (RES) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         rw_q       <= 1'b1;
         idx_q      <= '0;
         t_cen_q    <= '1;
         readyn_q   <= 1'b1;
         szrqn_q    <= 1'b1;
         berr_q     <= 1'b0;
         d_i_q      <= '0;
         err_addr_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge values.
         state_q    <= state_d;
         addr_q     <= addr_d;
         rw_q       <= rw_d;
         idx_q      <= idx_d;
         t_cen_q    <= t_cen_d;
         readyn_q   <= readyn_d;
         szrqn_q    <= szrqn_d;
         berr_q     <= berr_d;
         d_i_q      <= d_i_d;
         err_addr_q <= err_addr_d;
      end
   end

   assign T_CEn    = t_cen_q;
   // A read keeps the write enable high; a write follows the chip enable.
   assign T_WEn    = t_cen_q | {NT{rw_q}};
   assign READYn   = readyn_q;
   assign SZRQn    = szrqn_q;
   assign BERR     = berr_q;
   assign D_I      = d_i_q;
   assign ERR_ADDR = err_addr_q;

endmodule
